// File: rtl/mem_access_unit.sv
// Initiator for a single-port data memory with one-cycle registered reads.
// Sequences LOAD/STORE/ADD/SWAP requests and returns exactly one response per request.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  output logic [7:0]        fault_count,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] RF_Rd_data,
  output logic              CNTRL_write_en,
  input  logic [DATA_W-1:0] Mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;

  // One extra bit so DEPTH itself is representable when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_old;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_fault;
  logic [7:0]          r_fault_count;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_we;
  logic                w_addr_fault;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_addr_fault = ({1'b0, req_addr} >= DEPTH_L);

  // Write enable is gated by reset so an aborted op can never write.
  assign CNTRL_write_en = r_we & RESET_n;
  assign req_ready      = (r_state == S_IDLE) & RESET_n;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_fault     = r_resp_fault;
  assign fault_count    = r_fault_count;
  assign Mem_addr       = r_mem_addr;
  assign RF_Rd_data     = r_wr_data;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_LOAD;
      r_data        <= '0;
      r_old         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_fault  <= 1'b0;
      r_fault_count <= 8'd0;
      r_mem_addr    <= '0;
      r_wr_data     <= '0;
      r_we          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            r_data <= req_data;
            if (w_addr_fault) begin
              r_resp_valid  <= 1'b1;
              r_resp_data   <= '0;
              r_resp_fault  <= 1'b1;
              r_fault_count <= sat_inc8(r_fault_count);
              r_state       <= S_RESP;
            end else begin
              r_mem_addr   <= req_addr;
              r_resp_fault <= 1'b0;
              if (req_op == OP_STORE) begin
                r_we      <= 1'b1;
                r_wr_data <= req_data;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        // ACCESS -> address on the bus; STOREs write at the end of this cycle
        S_ACCESS: begin
          r_we <= 1'b0;
          if (r_op == OP_STORE) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
            r_state      <= S_RESP;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        // CAPTURE -> registered read data is valid this cycle
        S_CAPTURE: begin
          r_old <= Mem_data;
          if (r_op == OP_LOAD) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= Mem_data;
            r_state      <= S_RESP;
          end else begin
            r_we      <= 1'b1;
            r_wr_data <= (r_op == OP_ADD) ? Mem_data + r_data : r_data;
            r_state   <= S_WRITE;
          end
        end
        // WRITE -> read-modify-write commit; returns the pre-update value
        S_WRITE: begin
          r_we         <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_data  <= r_old;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural memory plus a transaction-level reference model
// checked every cycle, with directed transactions carrying hand-computed results.
module tb_mem_access_unit;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);

  localparam logic [1:0] LOAD = 2'b00, STORE = 2'b01, ADD = 2'b10, SWAP = 2'b11;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_fault;
  logic [7:0]        fault_count;
  logic [ADDR_W-1:0] Mem_addr;
  logic [DATA_W-1:0] RF_Rd_data;
  logic              CNTRL_write_en;
  logic [DATA_W-1:0] Mem_data;

  always #5 CLOCK_50 = ~CLOCK_50;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .RESET_n(RESET_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_fault(resp_fault), .fault_count(fault_count),
    .Mem_addr(Mem_addr), .RF_Rd_data(RF_Rd_data), .CNTRL_write_en(CNTRL_write_en),
    .Mem_data(Mem_data)
  );

  // Memory array: registered read, no read data on a write cycle.
  logic [DATA_W-1:0] phys [DEPTH];
  initial Mem_data = '0;
  always @(posedge CLOCK_50) begin
    if (CNTRL_write_en) begin
      if (int'(Mem_addr) < DEPTH) phys[Mem_addr[AW-1:0]] <= RF_Rd_data;
    end else begin
      Mem_data <= (int'(Mem_addr) < DEPTH) ? phys[Mem_addr[AW-1:0]] : '0;
    end
  end

  int checks = 0;
  int errors = 0;
  bit en_chk = 0;
  bit we_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: golden array, one outstanding request, latency per op.
  logic [DATA_W-1:0] gold [DEPTH];
  bit                m_busy = 0;
  int                m_cyc, m_lat, m_wcyc, m_fc = 0;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_resp, m_wval;
  bit                m_fault;

  always @(negedge CLOCK_50) begin
    bit ev, ew, was;
    we_seen = we_seen | (CNTRL_write_en === 1'b1);
    ev = m_busy && (m_cyc >= m_lat);
    ew = RESET_n && m_busy && (m_wcyc != 0) && (m_cyc == m_wcyc);
    if (en_chk) begin
      chk("req_ready", req_ready, RESET_n && !m_busy);
      chk("resp_valid", resp_valid, ev);
      if (ev) begin
        chk("resp_data", resp_data, m_resp);
        chk("resp_fault", resp_fault, m_fault);
      end
      chk("fault_count", fault_count, m_fc);
      chk("write_en", CNTRL_write_en, ew);
      if (ew) begin
        chk("mem_addr", Mem_addr, m_addr);
        chk("wr_data", RF_Rd_data, m_wval);
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (!RESET_n) begin
      m_busy = 0;
      m_fc   = 0;
    end else begin
      was = m_busy;
      if (m_busy) begin
        if (ew) gold[m_addr[AW-1:0]] = m_wval;
        if (ev && resp_ready) m_busy = 0;
        else m_cyc++;
      end
      if (!was && req_valid) begin
        m_busy = 1;
        m_cyc  = 1;
        m_addr = req_addr;
        m_wcyc = 0;
        m_resp = '0;
        m_wval = req_data;
        if (int'(req_addr) >= DEPTH) begin
          m_fault = 1;
          m_lat   = 1;
          m_fc    = (m_fc < 255) ? m_fc + 1 : 255;
        end else begin
          m_fault = 0;
          case (req_op)
            LOAD:  begin m_lat = 3; m_resp = gold[req_addr[AW-1:0]]; end
            STORE: begin m_lat = 2; m_wcyc = 1; end
            ADD:   begin m_lat = 4; m_wcyc = 3; m_resp = gold[req_addr[AW-1:0]];
                         m_wval = gold[req_addr[AW-1:0]] + req_data; end
            default: begin m_lat = 4; m_wcyc = 3; m_resp = gold[req_addr[AW-1:0]]; end
          endcase
        end
      end
    end
  end

  // Presents a request just after a rising edge; returns just after its accept edge.
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bit done = 0;
    req_valid = 1; req_op = op; req_addr = a; req_data = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLOCK_50);
      if (req_ready) begin
        @(posedge CLOCK_50); #1;
        done = 1;
      end
    end
    req_valid = 0;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  task automatic wait_resp(output logic [DATA_W-1:0] d, output logic f, output int lat);
    bit got = 0;
    lat = 0; d = '0; f = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge CLOCK_50);
      lat++;
      if (resp_valid && resp_ready) begin
        d = resp_data; f = resp_fault; got = 1;
      end
    end
    if (got) begin
      @(posedge CLOCK_50); #1;
    end else begin
      errors++;
      $display("FAIL resp_timeout: got no response expected response at %0t", $time);
    end
  endtask

  task automatic txn(input string name, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_d,
                     input logic exp_f, input int exp_lat);
    logic [DATA_W-1:0] rd;
    logic rf;
    int lat;
    issue(op, a, d);
    wait_resp(rd, rf, lat);
    chk({name, "_data"}, rd, exp_d);
    chk({name, "_fault"}, rf, exp_f);
    chk({name, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic rf;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      phys[i] = '0;
      gold[i] = '0;
    end
    RESET_n = 0; req_valid = 0; req_op = LOAD; req_addr = '0; req_data = '0; resp_ready = 1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    en_chk = 1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_fault_count", fault_count, 0);
    chk("rst_mem_addr", Mem_addr, 0);
    chk("rst_wr_data", RF_Rd_data, 0);
    chk("rst_write_en", CNTRL_write_en, 0);
    chk("rst_req_ready", req_ready, 0);
    RESET_n = 1;
    @(posedge CLOCK_50); #1;

    txn("store3", STORE, 16'd3, 32'hDEADBEEF, 32'h0, 0, 2);
    txn("load3",  LOAD,  16'd3, 32'h0, 32'hDEADBEEF, 0, 3);

    txn("store5", STORE, 16'd5, 32'hFFFFFFFF, 32'h0, 0, 2);
    txn("add5",   ADD,   16'd5, 32'd2, 32'hFFFFFFFF, 0, 4);
    txn("load5",  LOAD,  16'd5, 32'h0, 32'h00000001, 0, 3);

    txn("store7", STORE, 16'd7, 32'hAAAA5555, 32'h0, 0, 2);
    txn("swap7",  SWAP,  16'd7, 32'h12345678, 32'hAAAA5555, 0, 4);
    txn("load7",  LOAD,  16'd7, 32'h0, 32'h12345678, 0, 3);

    we_seen = 0;
    txn("fault16",   LOAD,  16'd16,   32'h0, 32'h0, 1, 1);
    txn("faultFFFF", STORE, 16'hFFFF, 32'h0BADF00D, 32'h0, 1, 1);
    chk("fault_count_2", fault_count, 8'd2);
    chk("fault_no_write", we_seen, 0);
    for (int i = 0; i < 258; i++) begin
      issue(LOAD, 16'd16 + 16'(i % 100), 32'h0);
      wait_resp(rd, rf, lat);
    end
    chk("fault_count_sat", fault_count, 8'd255);
    chk("fault_sat_no_write", we_seen, 0);

    // Back-pressure: response held while a new request waits.
    resp_ready = 0;
    issue(LOAD, 16'd3, 32'h0);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge CLOCK_50);
      lat++;
    end
    chk("hold_lat", lat, 3);
    @(posedge CLOCK_50); #1;
    req_valid = 1; req_op = STORE; req_addr = 16'd9; req_data = 32'h5A5A5A5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, 32'hDEADBEEF);
      chk("hold_ready", req_ready, 0);
    end
    @(posedge CLOCK_50); #1;
    resp_ready = 1;
    @(negedge CLOCK_50);
    chk("hs_valid", resp_valid, 1);
    chk("hs_req_ready", req_ready, 0);
    @(negedge CLOCK_50);
    chk("post_hs_req_ready", req_ready, 1);
    chk("post_hs_valid", resp_valid, 0);
    @(posedge CLOCK_50); #1;
    req_valid = 0;
    wait_resp(rd, rf, lat);
    chk("store9_data", rd, 32'h0);
    chk("store9_lat", lat, 2);
    txn("load9", LOAD, 16'd9, 32'h0, 32'h5A5A5A5A, 0, 3);

    // Reset during the WRITE cycle of an ADD must suppress the write and the response.
    txn("store2", STORE, 16'd2, 32'd10, 32'h0, 0, 2);
    issue(ADD, 16'd2, 32'd5);
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    RESET_n = 0;
    @(negedge CLOCK_50);
    chk("abort_write_en", CNTRL_write_en, 0);
    chk("abort_wr_data", RF_Rd_data, 32'd15);
    @(posedge CLOCK_50); #1;
    RESET_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      chk("abort_no_resp", resp_valid, 0);
    end
    chk("abort_fault_count", fault_count, 8'd0);
    @(posedge CLOCK_50); #1;
    txn("load2", LOAD, 16'd2, 32'h0, 32'd10, 0, 3);

    for (int i = 0; i < DEPTH; i++) chk("array_final", phys[i], gold[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory port: accepts load, store and read-modify-write requests from the core over a valid/ready handshake. It drives the memory's address, write-data and write-enable inputs, and collects the memory's registered read data. It sequences around the memory's one-cycle read latency and its rule that a write cycle returns no read data. It also rejects out-of-range addresses before they reach the array, and returns one response per request.

## Interface
- ADDR_W, 16, width of request address and Mem_addr
- DATA_W, 32, width of data paths
- DEPTH, 16, number of implemented memory words; addresses >= DEPTH fault

- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  2  00 LOAD, 01 STORE, 10 ADD (mem += data, return old), 11 SWAP (mem = data, return old)
- req_addr  in  ADDR_W  word address
- req_data  in  DATA_W  store/operand data
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_data  out  DATA_W  loaded/old value; 0 for STORE and faults
- resp_fault  out  1  request address was out of range
- fault_count  out  8  saturating count of faulted requests
- Mem_addr  out  ADDR_W  to memory address
- RF_Rd_data  out  DATA_W  to memory write data
- CNTRL_write_en  out  1  to memory write enable
- Mem_data  in  DATA_W  from memory, registered read data

## Operation
- States: IDLE, ACCESS, CAPTURE, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register op, addr, data.
  - If addr >= DEPTH (unsigned, full ADDR_W): go RESP with resp_fault=1, resp_data=0. Increment fault_count, saturating at 255. No memory access is issued.
  - Otherwise go ACCESS.
- ACCESS: Mem_addr = registered addr.
  - STORE: CNTRL_write_en=1, RF_Rd_data = registered data; then RESP.
  - LOAD/ADD/SWAP: CNTRL_write_en=0; then CAPTURE.
- CAPTURE: Mem_data is valid; register it as old value.
  - LOAD: go RESP.
  - ADD/SWAP: go WRITE.
- WRITE: CNTRL_write_en=1, Mem_addr = addr. RF_Rd_data = old + data (mod 2^DATA_W, carry dropped) for ADD, or data for SWAP. Then RESP.
- RESP: resp_valid=1 with resp_data/resp_fault held stable until resp_valid&&resp_ready, then IDLE.
- req_ready is 1 only in IDLE; at most one request is outstanding.
- CNTRL_write_en is 1 only in ACCESS (STORE) and WRITE, and is forced 0 whenever RESET_n=0.
- Mem_addr and RF_Rd_data hold their last values outside write/access states.

## Timing
- Accept edge = cycle 0. resp_valid first asserts at:
  - fault: cycle 1
  - STORE: cycle 2
  - LOAD: cycle 3
  - ADD/SWAP: cycle 4
- Memory write occurs at the end of the ACCESS cycle (STORE) or the WRITE cycle (ADD/SWAP).
- Next request may be accepted in the cycle after the response handshake (IDLE). Back-to-back STOREs therefore complete every 3 cycles with resp_ready held 1.
- Reset values (the edge sampling RESET_n=0):
  - state IDLE
  - resp_valid 0, resp_data 0, resp_fault 0
  - fault_count 0
  - Mem_addr 0, RF_Rd_data 0, CNTRL_write_en 0
  - req_ready is 0 while RESET_n=0
- Reset mid-operation aborts the op: no write is issued in any cycle with RESET_n=0, and no response is produced.
- A request presented while busy is not accepted; req_* must be held by the core.
- resp_ready asserted before resp_valid has no effect.

## Test plan
- Reset, STORE addr 3 data 0xDEADBEEF, then LOAD addr 3 -> STORE response at cycle 2 with data 0, fault 0; LOAD response at cycle 3 with resp_data 0xDEADBEEF.
- STORE addr 5 0xFFFFFFFF, ADD addr 5 data 2, LOAD addr 5 -> ADD returns 0xFFFFFFFF; LOAD returns 0x00000001 (wrap).
- SWAP addr 7 data 0x12345678 after STORE 0xAAAA5555 -> returns 0xAAAA5555; subsequent LOAD returns 0x12345678.
- LOAD addr 16 and STORE addr 0xFFFF -> each responds at cycle 1 with fault=1, data 0. CNTRL_write_en never asserts; fault_count=2. 260 faults -> fault_count=255.
- Hold resp_ready=0 for 5 cycles after LOAD response -> resp_valid and resp_data stable, req_ready=0. New req_valid is not accepted until the cycle after the handshake.
- Assert RESET_n=0 during WRITE state of an ADD to addr 2 holding 10 -> CNTRL_write_en=0 that cycle; no response; a following LOAD addr 2 returns 10.
